// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider with start/done handshake and fixed WIDTH+1 cycle latency.
// Signed mode divides magnitudes and then applies signs (truncating division).
module nonrestoring_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic             sa;
  logic             sb;
  logic             ovf_pend;

  logic             accept;
  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_step;
  logic [WIDTH:0]   a_fix;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;

  always_comb begin
    accept       = start && (state == ST_IDLE || state == ST_DONE);
    in_sa        = signed_mode & dividend[WIDTH-1];
    in_sb        = signed_mode & divisor[WIDTH-1];
    dividend_mag = in_sa ? (~dividend + 1'b1) : dividend;
    divisor_mag  = in_sb ? (~divisor + 1'b1) : divisor;
    // A is WIDTH+1 bits; the shifted value may wrap but the add/sub result always fits.
    a_sh         = {a[WIDTH-1:0], q[WIDTH-1]};
    a_step       = a[WIDTH] ? (a_sh + {1'b0, m}) : (a_sh - {1'b0, m});
    a_fix        = a[WIDTH] ? (a + {1'b0, m}) : a;
    q_signed     = (sa ^ sb) ? (~q + 1'b1) : q;
    r_signed     = sa ? (~a_fix[WIDTH-1:0] + 1'b1) : a_fix[WIDTH-1:0];
    busy         = (state == ST_ITER) || (state == ST_FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      count     <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ovf_pend  <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            sa       <= in_sa;
            sb       <= in_sb;
            q        <= dividend_mag;
            m        <= divisor_mag;
            a        <= '0;
            count    <= CW'(WIDTH);
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_ITER;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          a     <= a_step;
          q     <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          count <= count - 1'b1;
          if (count == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          a         <= a_fix;
          quotient  <= q_signed;
          remainder <= r_signed;
          ovf       <= ovf_pend;
          done      <= 1'b1;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and random bench for nonrestoring_divider; expected results are queued at start
// and compared when done rises.
module tb_nonrestoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dbz;
  logic        ovf;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  nonrestoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .dbz         (dbz),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sm, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic sa, sb;
    logic [15:0] ma, mb, mq, mr;
    sa = sm & a[15];
    sb = sm & b[15];
    ma = sa ? 16'(-a) : a;
    mb = sb ? 16'(-b) : b;
    if (b == 16'h0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.ovf = 1'b0;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
      e.q   = (sa ^ sb) ? 16'(-mq) : mq;
      e.r   = sa ? 16'(-mr) : mr;
      e.dbz = 1'b0;
      e.ovf = sm && (a == 16'h8000) && (b == 16'hFFFF);
    end
    return e;
  endfunction

  // Drive a start in the current cycle and queue its expectation.
  task automatic drive_start(input logic sm, input logic [15:0] a, input logic [15:0] b,
                             input exp_t e);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'hBEEF;
  endtask

  task automatic start_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                          input exp_t e);
    @(posedge clk);
    #1;
    drive_start(sm, a, b, e);
  endtask

  // n counts edges since the accept edge; returns in the done cycle, #1 after the edge.
  task automatic wait_done(input int n0, input int lat, input logic exp_busy);
    int   n;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < lat + 10) begin
      chk("busy_during_op", 32'(busy), 32'(exp_busy));
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_at_done", 32'(busy), 32'(0));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("dbz", 32'(dbz), 32'(e.dbz));
      chk("ovf", 32'(ovf), 32'(e.ovf));
    end else begin
      chk("scoreboard_nonempty", 32'(0), 32'(1));
    end
  endtask

  task automatic check_done_pulse();
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic d,
                              input logic o);
    exp_t e;
    e.q = q; e.r = r; e.dbz = d; e.ovf = o;
    return e;
  endfunction

  initial begin
    int   n;
    logic seen_done;
    logic sm;
    logic [15:0] ra, rb;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_q", 32'(quotient), 32'(0));
    chk("reset_r", 32'(remainder), 32'(0));
    chk("reset_flags", 32'({dbz, ovf}), 32'(0));
    rst = 1'b0;

    // T1 unsigned 100/7
    start_op(1'b0, 16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);
    check_done_pulse();

    // T2 signed mixed signs
    start_op(1'b1, 16'hFF9C, 16'd7, mk(16'hFFF2, 16'hFFFE, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);
    start_op(1'b1, 16'd100, 16'hFFF9, mk(16'hFFF2, 16'd2, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);

    // T3 divide by zero in both modes
    start_op(1'b0, 16'd5, 16'd0, mk(16'hFFFF, 16'd5, 1'b1, 1'b0));
    wait_done(0, 0, 1'b0);
    check_done_pulse();
    chk("dbz_busy_after", 32'(busy), 32'(0));
    start_op(1'b1, 16'd5, 16'd0, mk(16'hFFFF, 16'd5, 1'b1, 1'b0));
    wait_done(0, 0, 1'b0);

    // T4 signed overflow; also checks dbz cleared by the next accept
    start_op(1'b1, 16'h8000, 16'hFFFF, mk(16'h8000, 16'h0000, 1'b0, 1'b1));
    wait_done(0, 17, 1'b1);

    // Unsigned full range
    start_op(1'b0, 16'hFFFF, 16'h0001, mk(16'hFFFF, 16'h0000, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);

    // T5 start while busy is ignored
    start_op(1'b0, 16'd50, 16'd3, mk(16'd16, 16'd2, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd9; divisor = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, 17, 1'b1);
    check_done_pulse();

    // T6 reset mid-operation aborts without done
    @(posedge clk);
    #1;
    signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_q", 32'(quotient), 32'(0));
    chk("abort_r", 32'(remainder), 32'(0));
    chk("abort_flags", 32'({dbz, ovf}), 32'(0));
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'(0));

    start_op(1'b0, 16'd255, 16'd16, mk(16'd15, 16'd15, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);
    // Back-to-back start in the DONE cycle
    drive_start(1'b1, 16'hFF38, 16'd10, mk(16'hFFEC, 16'h0000, 1'b0, 1'b0));
    wait_done(0, 17, 1'b1);
    drive_start(1'b0, 16'd7, 16'd0, mk(16'hFFFF, 16'd7, 1'b1, 1'b0));
    wait_done(0, 0, 1'b0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom >> (4 * (i % 4)));
      if (rb == 16'h0) rb = 16'h0003;
      start_op(sm, ra, rb, model(sm, ra, rb));
      wait_done(0, 17, 1'b1);
    end

    n = sb_q.size();
    chk("scoreboard_empty", 32'(n), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
